matrix_stream_tx: RTL and testbench

// - Transmit end of the accumulator stream consumed by the GELU/requant tops.
// - Reads a DIM1 x DIM2 matrix of signed D_W_ACC words from a 1-cycle-latency buffer.
// - Emits the words as an AXI-stream (tdata/tvalid/tready/tlast), with tlast on the final element.
// - Tracks layer/batch position so downstream parameter ROMs stay aligned.

---
 rtl/matrix_stream_tx.sv | 200 ++++++++++++++++++++
 tb/tb_matrix_stream_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_tx.sv
// Streams a DIM1 x DIM2 matrix from a 1-cycle-latency buffer as AXI-stream beats,
// with a 2-entry skid FIFO and layer/batch tracking. Define STREAM_TX_TRANSPOSE_EN for column-major order.
module matrix_stream_tx #(
  parameter int D_W_ACC      = 32,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 16,
  parameter int LAYERS       = 12,
  parameter int BATCHES      = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic [MATRIXSIZE_W-1:0]      DIM1,
  input  logic [MATRIXSIZE_W-1:0]      DIM2,
  output logic                         mem_rden,
  output logic [ADDR_W-1:0]            mem_rdaddr,
  input  logic [D_W_ACC-1:0]           mem_rddata,
  output logic [D_W_ACC-1:0]           out_tdata,
  output logic                         out_tvalid,
  input  logic                         out_tready,
  output logic                         out_tlast,
  output logic [$clog2(LAYERS)-1:0]    layer,
  output logic [$clog2(BATCHES):0]     batch
);

  localparam int LAYER_W = $clog2(LAYERS);
  localparam int BATCH_W = $clog2(BATCHES) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e                    state_q, state_d;
  logic                      busy_q, busy_d, done_q, done_d;
  logic [MATRIXSIZE_W-1:0]   dim1_q, dim1_d, dim2_q, dim2_d;
  logic [MATRIXSIZE_W-1:0]   row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      rd_done_q, rd_done_d;
  logic                      inflight_q, inflight_d, inflight_last_q, inflight_last_d;
  logic [D_W_ACC-1:0]        fifo_data_q [2];
  logic [D_W_ACC-1:0]        fifo_data_d [2];
  logic                      fifo_last_q [2];
  logic                      fifo_last_d [2];
  logic                      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]                count_q, count_d;
  logic [LAYER_W-1:0]        layer_q, layer_d;
  logic [BATCH_W-1:0]        batch_q, batch_d;

  logic       push, pop, last_hs, is_last_rd;
  logic [2:0] occ_after_pop;

  // NOTE: every _d gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    dim1_d          = dim1_q;
    dim2_d          = dim2_q;
    row_d           = row_q;
    col_d           = col_q;
    addr_d          = addr_q;
    rd_done_d       = rd_done_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    layer_d         = layer_q;
    batch_d         = batch_q;

    pop     = (count_q != 2'd0) && out_tready;
    push    = inflight_q;
    last_hs = pop && fifo_last_q[rd_ptr_q];

    // Credit check counts the slot freed by this cycle's pop, which keeps 1 beat/cycle.
    occ_after_pop = {1'b0, count_q} - {2'b0, pop} + {2'b0, inflight_q};
    is_last_rd    = (row_q == dim1_q - 1'b1) && (col_q == dim2_q - 1'b1);
    mem_rden      = (state_q == S_RUN) && !rd_done_q && (occ_after_pop < 3'd2);

    inflight_d      = mem_rden;
    inflight_last_d = is_last_rd;

    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_rddata;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dim1_d    = DIM1;
          dim2_d    = DIM2;
          row_d     = '0;
          col_d     = '0;
          addr_d    = '0;
          rd_done_d = 1'b0;
          if (DIM1 != '0 && DIM2 != '0) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (mem_rden) begin
          if (is_last_rd) rd_done_d = 1'b1;
`ifdef STREAM_TX_TRANSPOSE_EN
          if (row_q == dim1_q - 1'b1) begin
            row_d  = '0;
            col_d  = col_q + 1'b1;
            addr_d = ADDR_W'(col_q) + 1'b1;
          end else begin
            row_d  = row_q + 1'b1;
            addr_d = addr_q + ADDR_W'(dim2_q);
          end
`else
          addr_d = addr_q + 1'b1;
          if (col_q == dim2_q - 1'b1) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
`endif
        end
        if (last_hs) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (batch_q == BATCH_W'(BATCHES - 1)) begin
            batch_d = '0;
            layer_d = (layer_q == LAYER_W'(LAYERS - 1)) ? '0 : layer_q + 1'b1;
          end else begin
            batch_d = batch_q + 1'b1;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      dim1_q          <= '0;
      dim2_q          <= '0;
      row_q           <= '0;
      col_q           <= '0;
      addr_q          <= '0;
      rd_done_q       <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      // NOTE: the two skid entries are reset so out_tdata reads 0 out of reset; a large RAM would not be.
      fifo_data_q     <= '{default: '0};
      fifo_last_q     <= '{default: 1'b0};
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= '0;
      layer_q         <= '0;
      batch_q         <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      dim1_q          <= dim1_d;
      dim2_q          <= dim2_d;
      row_q           <= row_d;
      col_q           <= col_d;
      addr_q          <= addr_d;
      rd_done_q       <= rd_done_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      fifo_data_q     <= fifo_data_d;
      fifo_last_q     <= fifo_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      layer_q         <= layer_d;
      batch_q         <= batch_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rdaddr = addr_q;
  assign out_tvalid = (count_q != 2'd0);
  assign out_tdata  = fifo_data_q[rd_ptr_q];
  assign out_tlast  = out_tvalid && fifo_last_q[rd_ptr_q];
  assign layer      = layer_q;
  assign batch      = batch_q;

endmodule

// File: tb/tb_matrix_stream_tx.sv
// Randomized bench for matrix_stream_tx: a scoreboard built from the matrix order and buffer
// contents checks every cycle; a few literal expectations pin the model.
module tb_matrix_stream_tx;

  localparam int LAYERS  = 12;
  localparam int BATCHES = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] DIM1 = '0, DIM2 = '0;
  logic        busy, done, mem_rden, out_tvalid, out_tlast;
  logic        out_tready = 1'b1;
  logic [15:0] mem_rdaddr;
  logic [31:0] mem_rddata = '0;
  logic [31:0] out_tdata;
  logic [3:0]  layer;
  logic [0:0]  batch;

  matrix_stream_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .DIM1(DIM1), .DIM2(DIM2), .mem_rden(mem_rden), .mem_rdaddr(mem_rdaddr),
    .mem_rddata(mem_rddata), .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast), .layer(layer), .batch(batch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Buffer model: 1-cycle read latency, garbage when not read.
  logic [31:0] buf_mem [0:255];
  always @(posedge clk) mem_rddata <= mem_rden ? buf_mem[mem_rdaddr[7:0]] : $urandom;

  // Ready driver: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
  int ready_mode = 0;
  int phase = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = (phase % 3 == 0);
      default: out_tready = ($urandom_range(0, 3) != 0);
    endcase
    phase++;
  end

  // Behavioural model and per-cycle compare
  typedef struct { logic [31:0] data; logic last; } beat_t;
  beat_t       exp_beat [$];
  int          exp_addr [$];
  beat_t       b;
  logic        m_busy = 0, m_done = 0, nxt_busy, nxt_done;
  int          m_layer = 0, m_batch = 0;
  int          rd_cnt = 0, hs_cnt = 0, cyc_n = 0, n, a;
  logic        stall_prev = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [31:0] seen_data [$];
  int          seen_cyc  [$];

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_beat.delete(); exp_addr.delete();
      m_busy = 0; m_done = 0; m_layer = 0; m_batch = 0;
      rd_cnt = 0; hs_cnt = 0; stall_prev = 0;
    end else begin
      cyc_n++;
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("layer", layer, m_layer);
      check("batch", batch, m_batch);
      nxt_busy = m_busy;
      nxt_done = 1'b0;

      if (!m_busy) begin
        check("rden_idle", mem_rden, 0);
        check("tvalid_idle", out_tvalid, 0);
      end else if (mem_rden) begin
        if (exp_addr.size() == 0) check("rden_extra", mem_rden, 0);
        else check("rdaddr", mem_rdaddr, exp_addr.pop_front());
        rd_cnt++;
      end

      if (stall_prev) begin
        check("hold_valid", out_tvalid, 1);
        check("hold_data", out_tdata, prev_data);
        check("hold_last", out_tlast, prev_last);
      end

      if (out_tvalid && out_tready) begin
        hs_cnt++;
        if (exp_beat.size() == 0) check("beat_extra", out_tvalid, 0);
        else begin
          b = exp_beat.pop_front();
          check("tdata", out_tdata, b.data);
          check("tlast", out_tlast, b.last);
          seen_data.push_back(out_tdata);
          seen_cyc.push_back(cyc_n);
          if (b.last) begin
            nxt_busy = 0;
            nxt_done = 1;
            if (m_batch + 1 == BATCHES) begin
              m_batch = 0;
              m_layer = (m_layer + 1) % LAYERS;
            end else m_batch++;
          end
        end
      end
      if (m_busy) check("outstanding", (rd_cnt - hs_cnt) <= 2, 1);

      stall_prev = out_tvalid && !out_tready;
      prev_data  = out_tdata;
      prev_last  = out_tlast;

      if (start && !m_busy && !m_done) begin
        if (DIM1 != 0 && DIM2 != 0) begin
          n = int'(DIM1) * int'(DIM2);
          for (int k = 0; k < n; k++) begin
`ifdef STREAM_TX_TRANSPOSE_EN
            a = (k % int'(DIM1)) * int'(DIM2) + k / int'(DIM1);
`else
            a = k;
`endif
            exp_addr.push_back(a);
            exp_beat.push_back('{buf_mem[a], k == n - 1});
          end
          nxt_busy = 1;
          rd_cnt = 0;
          hs_cnt = 0;
        end else nxt_done = 1;
      end
      m_busy = nxt_busy;
      m_done = nxt_done;
    end
  end

  task automatic do_start(input int d1, input int d2);
    @(posedge clk); #1;
    DIM1 = 16'(d1); DIM2 = 16'(d2); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_seen", done, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int pin_seq [6];
  int lat;

  initial begin
    for (int i = 0; i < 256; i++) buf_mem[i] = 32'(i + 100);
`ifdef STREAM_TX_TRANSPOSE_EN
    pin_seq = '{100, 103, 101, 104, 102, 105};
`else
    pin_seq = '{100, 101, 102, 103, 104, 105};
`endif

    // Reset values
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tvalid", out_tvalid, 0);
    check("rst_rden", mem_rden, 0);
    check("rst_tdata", out_tdata, 0);
    check("rst_layer", layer, 0);
    check("rst_batch", batch, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 2x3, always ready: latency, consecutive beats, tlast, layer advance
    ready_mode = 0;
    seen_data.delete(); seen_cyc.delete();
    do_start(2, 3);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (out_tvalid) break;
    end
    check("first_valid_lat", lat <= 3, 1);
    wait_done(50);
    check("pin_count", seen_data.size(), 6);
    if (seen_data.size() == 6) begin
      for (int k = 0; k < 6; k++) check("pin_beat", seen_data[k], pin_seq[k]);
      check("pin_consecutive", seen_cyc[5] - seen_cyc[0], 5);
    end
    check("pin_layer1", layer, 1);

    // Same matrix with ready pattern 1,0,0
    ready_mode = 1; phase = 0;
    do_start(2, 3);
    wait_done(100);
    check("pin_layer2", layer, 2);

    // Zero dimension: no reads, no beats, done pulses, counters held
    ready_mode = 0;
    do_start(0, 4);
    wait_done(10);
    check("pin_zero_layer", layer, 2);

    // Second start during RUN with different dims is ignored
    ready_mode = 2;
    do_start(3, 3);
    @(posedge clk); #1;
    DIM1 = 16'd1; DIM2 = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(200);

    // Layer wrap over 12 single-element transfers
    do_reset();
    ready_mode = 0;
    for (int i = 0; i < 12; i++) begin
      do_start(1, 1);
      wait_done(20);
      check("pin_layer_wrap", layer, (i + 1) % 12);
    end

    // Reset mid-transfer after 3 of 6 beats, then a clean resend
    do_start(2, 3);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hs_cnt >= 3) break;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", out_tvalid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_rden", mem_rden, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_start(2, 3);
    wait_done(50);
    check("pin_after_rst_layer", layer, 1);

    // Randomized matrices, data and back-pressure
    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 64; i++) buf_mem[i] = $urandom;
      do_start($urandom_range(1, 5), $urandom_range(1, 5));
      wait_done(300);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
